sprite_fetch_gen: RTL and testbench

Pipelined, parametrised sprite address generator for the VGA path. Maps the raster pixel coordinate to a sprite ROM address for one sprite. Adds double-buffered position registers, integer upscaling, multi-frame animation and a fixed 2-cycle latency matched to a synchronous sprite ROM. Sits between the VGA timing generator and the sprite ROM/colour mux.

---
 rtl/sprite_fetch_gen.sv | 164 ++++++++++++++++
 tb/tb_sprite_fetch_gen.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch_gen.sv
// Sprite ROM address generator: raster (x,y) -> {frame,row,col}, fixed 2-cycle latency.
// Optional MIRROR_EN adds double-buffered horizontal/vertical mirroring.
module sprite_fetch_gen #(
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned SPR_W_LOG2  = 6,
  parameter int unsigned SPR_H_LOG2  = 6,
  parameter int unsigned SCALE_LOG2  = 0,
  parameter int unsigned FRAMES_LOG2 = 2,
  parameter int unsigned ANIM_DIV    = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [COORD_W-1:0]                            pixelx,
  input  logic [COORD_W-1:0]                            pixely,
  input  logic                                          pixel_valid,
  input  logic                                          frame_start,
  input  logic                                          pos_we,
  input  logic [COORD_W-1:0]                            posx_in,
  input  logic [COORD_W-1:0]                            posy_in,
  input  logic                                          anim_en,
`ifdef MIRROR_EN
  input  logic                                          mirror_x,
  input  logic                                          mirror_y,
`endif
  output logic [FRAMES_LOG2+SPR_H_LOG2+SPR_W_LOG2-1:0]  address,
  output logic                                          hit,
  output logic                                          pixel_valid_d,
  output logic [((FRAMES_LOG2 > 0) ? FRAMES_LOG2 : 1)-1:0] frame_idx
);

  localparam int unsigned ADDR_W = FRAMES_LOG2 + SPR_H_LOG2 + SPR_W_LOG2;
  localparam int unsigned FIDX_W = (FRAMES_LOG2 > 0) ? FRAMES_LOG2 : 1;
  localparam int unsigned CW1    = COORD_W + 1;
  localparam int unsigned EXT_X  = 1 << (SPR_W_LOG2 + SCALE_LOG2);
  localparam int unsigned EXT_Y  = 1 << (SPR_H_LOG2 + SCALE_LOG2);
  localparam int unsigned DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [COORD_W-1:0] pend_x, pend_y, act_x, act_y;
  logic               pend_mx, pend_my, act_mx, act_my;
  logic               mir_x_in, mir_y_in;

`ifdef MIRROR_EN
  assign mir_x_in = mirror_x;
  assign mir_y_in = mirror_y;
`else
  assign mir_x_in = 1'b0;
  assign mir_y_in = 1'b0;
`endif

  // Double-buffered position/mirror; a coincident write bypasses the pending copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_x  <= '0;
      pend_y  <= '0;
      act_x   <= '0;
      act_y   <= '0;
      pend_mx <= 1'b0;
      pend_my <= 1'b0;
      act_mx  <= 1'b0;
      act_my  <= 1'b0;
    end else begin
      if (pos_we) begin
        pend_x  <= posx_in;
        pend_y  <= posy_in;
        pend_mx <= mir_x_in;
        pend_my <= mir_y_in;
      end
      if (frame_start) begin
        act_x  <= pos_we ? posx_in  : pend_x;
        act_y  <= pos_we ? posy_in  : pend_y;
        act_mx <= pos_we ? mir_x_in : pend_mx;
        act_my <= pos_we ? mir_y_in : pend_my;
      end
    end
  end

  // Extent test one bit wider than the coordinate so the sprite clips instead of wrapping
  logic [CW1-1:0] px_w, py_w, ax_w, ay_w;
  logic           inside_c;

  always_comb begin
    px_w     = CW1'(pixelx);
    py_w     = CW1'(pixely);
    ax_w     = CW1'(act_x);
    ay_w     = CW1'(act_y);
    inside_c = pixel_valid
             && (px_w >= ax_w) && (px_w < ax_w + CW1'(EXT_X))
             && (py_w >= ay_w) && (py_w < ay_w + CW1'(EXT_Y));
  end

  // Stage 1: offsets and coverage
  logic [COORD_W-1:0] dx_q, dy_q;
  logic               inside_q, pv_q, mx_q, my_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_q     <= '0;
      dy_q     <= '0;
      inside_q <= 1'b0;
      pv_q     <= 1'b0;
      mx_q     <= 1'b0;
      my_q     <= 1'b0;
    end else begin
      dx_q     <= pixelx - act_x;
      dy_q     <= pixely - act_y;
      inside_q <= inside_c;
      pv_q     <= pixel_valid;
      mx_q     <= act_mx;
      my_q     <= act_my;
    end
  end

  // Stage 2: texel select and address assembly
  logic [SPR_W_LOG2-1:0] col_c;
  logic [SPR_H_LOG2-1:0] row_c;
  logic [ADDR_W-1:0]     addr_c;

  always_comb begin
    col_c  = SPR_W_LOG2'(dx_q >> SCALE_LOG2) ^ {SPR_W_LOG2{mx_q}};
    row_c  = SPR_H_LOG2'(dy_q >> SCALE_LOG2) ^ {SPR_H_LOG2{my_q}};
    addr_c = ADDR_W'({frame_idx, row_c, col_c});
  end

  // Address holds while off-sprite so the ROM bus stays quiet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address       <= '0;
      hit           <= 1'b0;
      pixel_valid_d <= 1'b0;
    end else begin
      if (inside_q) address <= addr_c;
      hit           <= inside_q;
      pixel_valid_d <= pv_q;
    end
  end

  // Animation stepping: divider advances once per frame while enabled
  logic [DIV_W-1:0]  div_q, div_n;
  logic [FIDX_W-1:0] frame_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      frame_idx <= '0;
    end else begin
      div_q     <= div_n;
      frame_idx <= frame_n;
    end
  end

  always_comb begin
    div_n   = div_q;
    frame_n = frame_idx;
    if (frame_start && anim_en) begin
      if (div_q == DIV_W'(ANIM_DIV - 1)) begin
        div_n = '0;
        if (FRAMES_LOG2 > 0) frame_n = frame_idx + FIDX_W'(1);
      end else begin
        div_n = div_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sprite_fetch_gen.sv
// Randomised and directed bench for sprite_fetch_gen: unscaled and 2x-scaled instances
// checked against an arithmetic reference model through a 2-deep expectation queue.
module tb_sprite_fetch_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pixelx, pixely, posx_in, posy_in;
  logic        pixel_valid, frame_start, pos_we, anim_en;
  logic        mirror_x, mirror_y;
  logic [13:0] addr0, addr1;
  logic        hit0, hit1, pvd0, pvd1;
  logic [1:0]  fidx0, fidx1;

  always #5 clk = ~clk;

  sprite_fetch_gen dut (
    .clk(clk), .rst_n(rst_n), .pixelx(pixelx), .pixely(pixely),
    .pixel_valid(pixel_valid), .frame_start(frame_start), .pos_we(pos_we),
    .posx_in(posx_in), .posy_in(posy_in), .anim_en(anim_en),
`ifdef MIRROR_EN
    .mirror_x(mirror_x), .mirror_y(mirror_y),
`endif
    .address(addr0), .hit(hit0), .pixel_valid_d(pvd0), .frame_idx(fidx0)
  );

  sprite_fetch_gen #(.SCALE_LOG2(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .pixelx(pixelx), .pixely(pixely),
    .pixel_valid(pixel_valid), .frame_start(frame_start), .pos_we(pos_we),
    .posx_in(posx_in), .posy_in(posy_in), .anim_en(anim_en),
`ifdef MIRROR_EN
    .mirror_x(mirror_x), .mirror_y(mirror_y),
`endif
    .address(addr1), .hit(hit1), .pixel_valid_d(pvd1), .frame_idx(fidx1)
  );

  typedef struct {
    logic        h0;
    logic [13:0] a0;
    logic        h1;
    logic [13:0] a1;
    logic        pv;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int m_pend_x, m_pend_y, m_act_x, m_act_y, m_div, m_frame, m_addr0, m_addr1;
  bit m_pend_mx, m_pend_my, m_act_mx, m_act_my;
  bit cur_ae, cur_mx, cur_my;

  function automatic bit calc_hit(int px, int py, bit pv, int s, int ax, int ay);
    return pv && px >= ax && px < ax + (64 << s) && py >= ay && py < ay + (64 << s);
  endfunction

  function automatic int calc_addr(int px, int py, int s, int ax, int ay, bit mx, bit my, int fr);
    int col, row;
    col = ((px - ax) >> s) % 64;
    row = ((py - ay) >> s) % 64;
    if (mx) col = 63 - col;
    if (my) row = 63 - row;
    return fr * 4096 + row * 64 + col;
  endfunction

  // One clock: check outputs of two cycles ago, then drive this cycle and predict it
  task automatic step(input int px, input int py, input bit pv, input bit fs,
                      input bit we, input int nx, input int ny);
    exp_t e;
    bit   h0, h1;
    @(negedge clk);
    if (q.size() >= 2) begin
      e = q.pop_front();
      n_tests++;
      if (hit0 !== e.h0) begin n_fail++; $display("FAIL hit0 got %0b exp %0b t=%0t", hit0, e.h0, $time); end
      n_tests++;
      if (addr0 !== e.a0) begin n_fail++; $display("FAIL addr0 got %0d exp %0d t=%0t", addr0, e.a0, $time); end
      n_tests++;
      if (hit1 !== e.h1) begin n_fail++; $display("FAIL hit1 got %0b exp %0b t=%0t", hit1, e.h1, $time); end
      n_tests++;
      if (addr1 !== e.a1) begin n_fail++; $display("FAIL addr1 got %0d exp %0d t=%0t", addr1, e.a1, $time); end
      n_tests++;
      if (pvd0 !== e.pv || pvd1 !== e.pv) begin
        n_fail++; $display("FAIL pvd got %0b/%0b exp %0b t=%0t", pvd0, pvd1, e.pv, $time);
      end
    end
    n_tests++;
    if (fidx0 !== 2'(m_frame) || fidx1 !== 2'(m_frame)) begin
      n_fail++; $display("FAIL frame_idx got %0d/%0d exp %0d t=%0t", fidx0, fidx1, m_frame, $time);
    end
    pixelx = 10'(px); pixely = 10'(py); pixel_valid = pv; frame_start = fs;
    pos_we = we; posx_in = 10'(nx); posy_in = 10'(ny); anim_en = cur_ae;
    mirror_x = cur_mx; mirror_y = cur_my;
    h0 = calc_hit(px, py, pv, 0, m_act_x, m_act_y);
    h1 = calc_hit(px, py, pv, 1, m_act_x, m_act_y);
    if (h0) m_addr0 = calc_addr(px, py, 0, m_act_x, m_act_y, m_act_mx, m_act_my, 0);
    if (h1) m_addr1 = calc_addr(px, py, 1, m_act_x, m_act_y, m_act_mx, m_act_my, 0);
    if (fs) begin
      m_act_x  = we ? nx : m_pend_x;
      m_act_y  = we ? ny : m_pend_y;
      m_act_mx = we ? cur_mx : m_pend_mx;
      m_act_my = we ? cur_my : m_pend_my;
    end
    if (we) begin
      m_pend_x = nx; m_pend_y = ny; m_pend_mx = cur_mx; m_pend_my = cur_my;
    end
    if (fs && cur_ae) begin
      m_div = m_div + 1;
      if (m_div == 8) begin m_div = 0; m_frame = (m_frame + 1) % 4; end
    end
    // frame field comes from the animation state after this cycle's update
    if (h0) m_addr0 = m_addr0 % 4096 + m_frame * 4096;
    if (h1) m_addr1 = m_addr1 % 4096 + m_frame * 4096;
    e.h0 = h0; e.a0 = 14'(m_addr0); e.h1 = h1; e.a1 = 14'(m_addr1); e.pv = pv;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic pixel(input int px, input int py);
    step(px, py, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(2);
  endtask

  task automatic apply_reset(input bit check_now);
    exp_t z;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (check_now) begin
      n_tests++;
      if (addr0 !== 14'd0 || hit0 !== 1'b0 || pvd0 !== 1'b0 || addr1 !== 14'd0 || hit1 !== 1'b0) begin
        n_fail++; $display("FAIL async_reset addr=%0d hit=%0b pvd=%0b exp 0", addr0, hit0, pvd0);
      end
    end
    pixelx = '0; pixely = '0; pixel_valid = 1'b0; frame_start = 1'b0; pos_we = 1'b0;
    posx_in = '0; posy_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pend_x = 0; m_pend_y = 0; m_act_x = 0; m_act_y = 0; m_div = 0; m_frame = 0;
    m_addr0 = 0; m_addr1 = 0; m_pend_mx = 0; m_pend_my = 0; m_act_mx = 0; m_act_my = 0;
    q.delete();
    z.h0 = 0; z.a0 = '0; z.h1 = 0; z.a1 = '0; z.pv = 0;
    q.push_back(z); q.push_back(z);
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    n_tests++;
    if (fidx0 !== 2'd0 || addr0 !== 14'd0) begin
      n_fail++; $display("FAIL reset_state frame_idx=%0d addr=%0d exp 0", fidx0, addr0);
    end
    // fill the pipeline with hits, then reset mid-frame
    for (int i = 0; i < 4; i++) step(5 + i, 5, 1'b1, 1'b0, 1'b0, 0, 0);
    apply_reset(1'b1);
    idle(1);
    n_tests++;
    if (fidx0 !== 2'd0) begin n_fail++; $display("FAIL reset_frame got %0d exp 0", fidx0); end
  endtask

  task automatic test_basic();
    step(0, 0, 1'b0, 1'b0, 1'b1, 100, 50);
    step(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    pixel(100, 50);
    n_tests++;
    if (hit0 !== 1'b1 || addr0 !== 14'd0) begin
      n_fail++; $display("FAIL basic_origin hit=%0b addr=%0d exp 1/0", hit0, addr0);
    end
    pixel(163, 113);
    n_tests++;
    if (hit0 !== 1'b1 || addr0 !== 14'd4095) begin
      n_fail++; $display("FAIL basic_corner hit=%0b addr=%0d exp 1/4095", hit0, addr0);
    end
    pixel(164, 50);
    n_tests++;
    if (hit0 !== 1'b0) begin n_fail++; $display("FAIL basic_right hit=%0b exp 0", hit0); end
    pixel(99, 50);
    n_tests++;
    if (hit0 !== 1'b0) begin n_fail++; $display("FAIL basic_left hit=%0b exp 0", hit0); end
  endtask

  task automatic test_clip();
    step(0, 0, 1'b0, 1'b1, 1'b1, 600, 0);
    pixel(639, 0);
    n_tests++;
    if (hit0 !== 1'b1 || addr0[5:0] !== 6'd39) begin
      n_fail++; $display("FAIL clip_edge hit=%0b col=%0d exp 1/39", hit0, addr0[5:0]);
    end
    pixel(0, 0);
    n_tests++;
    if (hit0 !== 1'b0 || hit1 !== 1'b0) begin
      n_fail++; $display("FAIL clip_nowrap hit=%0b/%0b exp 0", hit0, hit1);
    end
  endtask

  task automatic test_double_buffer();
    step(0, 0, 1'b0, 1'b0, 1'b1, 10, 10);
    pixel(10, 10);
    n_tests++;
    if (hit0 !== 1'b0) begin n_fail++; $display("FAIL dbuf_pending hit=%0b exp 0", hit0); end
    step(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    pixel(10, 10);
    n_tests++;
    if (hit0 !== 1'b1) begin n_fail++; $display("FAIL dbuf_applied hit=%0b exp 1", hit0); end
    step(0, 0, 1'b0, 1'b1, 1'b1, 200, 200);
    pixel(200, 200);
    n_tests++;
    if (hit0 !== 1'b1 || addr0[11:0] !== 12'd0) begin
      n_fail++; $display("FAIL dbuf_coincident hit=%0b addr=%0d exp 1/0", hit0, addr0);
    end
  endtask

  task automatic test_scale();
    step(0, 0, 1'b0, 1'b1, 1'b1, 0, 0);
    pixel(127, 127);
    n_tests++;
    if (hit1 !== 1'b1 || addr1[11:0] !== 12'd4095 || hit0 !== 1'b0) begin
      n_fail++; $display("FAIL scale_corner hit1=%0b addr1=%0d hit0=%0b exp 1/4095/0", hit1, addr1, hit0);
    end
    pixel(128, 0);
    n_tests++;
    if (hit1 !== 1'b0) begin n_fail++; $display("FAIL scale_past hit1=%0b exp 0", hit1); end
  endtask

  task automatic test_anim();
    cur_ae = 1'b1;
    for (int i = 0; i < 8; i++) step(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(1);
    n_tests++;
    if (fidx0 !== 2'd1) begin n_fail++; $display("FAIL anim_step got %0d exp 1", fidx0); end
    for (int i = 0; i < 24; i++) step(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(1);
    n_tests++;
    if (fidx0 !== 2'd0) begin n_fail++; $display("FAIL anim_wrap got %0d exp 0", fidx0); end
    for (int i = 0; i < 8; i++) step(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    cur_ae = 1'b0;
    for (int i = 0; i < 10; i++) step(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(1);
    n_tests++;
    if (fidx0 !== 2'd1) begin n_fail++; $display("FAIL anim_hold got %0d exp 1", fidx0); end
    pixel(3, 4);
    n_tests++;
    if (hit0 !== 1'b1 || addr0 !== 14'(4096 + 4 * 64 + 3)) begin
      n_fail++; $display("FAIL anim_addr hit=%0b addr=%0d exp 1/%0d", hit0, addr0, 4096 + 4 * 64 + 3);
    end
  endtask

`ifdef MIRROR_EN
  task automatic test_mirror();
    cur_mx = 1'b1;
    step(0, 0, 1'b0, 1'b1, 1'b1, 0, 0);
    cur_mx = 1'b0;
    pixel(0, 0);
    n_tests++;
    if (hit0 !== 1'b1 || addr0[5:0] !== 6'd63) begin
      n_fail++; $display("FAIL mirror_x hit=%0b col=%0d exp 1/63", hit0, addr0[5:0]);
    end
  endtask
`endif

  task automatic test_random();
    int ax, ay;
    ax = 300; ay = 200;
    for (int i = 0; i < 3000; i++) begin
      bit fs, we, pv;
      int px, py, nx, ny;
      fs = ($urandom_range(0, 49) == 0);
      we = ($urandom_range(0, 39) == 0);
      pv = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 199) == 0) cur_ae = ~cur_ae;
`ifdef MIRROR_EN
      cur_mx = 1'($urandom_range(0, 1));
      cur_my = 1'($urandom_range(0, 1));
`endif
      nx = $urandom_range(0, 1023);
      ny = $urandom_range(0, 1023);
      if (we) begin ax = nx; ay = ny; end
      px = ax + $urandom_range(0, 150) - 10;
      py = ay + $urandom_range(0, 150) - 10;
      if (px < 0) px = 0;
      if (px > 1023) px = 1023;
      if (py < 0) py = 0;
      if (py > 1023) py = 1023;
      step(px, py, pv, fs, we, nx, ny);
    end
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0;
    cur_ae = 1'b0; cur_mx = 1'b0; cur_my = 1'b0;
    mirror_x = 1'b0; mirror_y = 1'b0; anim_en = 1'b0;
    test_reset();
    test_basic();
    test_clip();
    test_double_buffer();
    test_scale();
    test_anim();
`ifdef MIRROR_EN
    test_mirror();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
